// File: rtl/c4_pkg.sv
// Shared types and constants for the Connect-4 game sequencer.
// Board geometry, cell/state encodings and the four scan directions.
package c4_pkg;
    localparam int ROWS      = 6;
    localparam int COLS      = 7;
    localparam int WIN_LEN   = 4;
    localparam int START_COL = 3;
    localparam int CELLS     = ROWS * COLS;
    localparam int RW        = $clog2(ROWS);
    localparam int CW        = $clog2(COLS);
    localparam int MW        = $clog2(CELLS + 1);

    typedef enum logic [1:0] {
        EMPTY    = 2'b00,
        P_A      = 2'b01,
        P_B      = 2'b10,
        WIN_MARK = 2'b11
    } cell_t;

    typedef enum logic [2:0] {
        SELECT, DROP, CHECK, RESOLVE, WIN, DRAW, CLEAR
    } state_t;

    typedef logic [ROWS-1:0][COLS-1:0][1:0] panel_t;

    // horizontal, vertical, diagonal, anti-diagonal
    localparam int DIR_DR [4] = '{0, 1, 1, 1};
    localparam int DIR_DC [4] = '{1, 0, 1, -1};

    // Off-board reads return EMPTY, which never matches a player colour.
    function automatic logic [1:0] cell_at(panel_t p, int r, int c);
        if (r < 0 || r >= ROWS || c < 0 || c >= COLS) return EMPTY;
        return p[r[RW-1:0]][c[CW-1:0]];
    endfunction

    function automatic logic [COLS-1:0] onehot(logic [CW-1:0] c);
        return COLS'(1) << c;
    endfunction
endpackage

// File: rtl/c4_game_ctrl_if.sv
// Button inputs and display-facing board outputs of the game sequencer.
interface c4_game_ctrl_if;
    import c4_pkg::*;

    logic            btn_left;
    logic            btn_right;
    logic            btn_drop;
    panel_t          panel;
    logic [COLS-1:0] play;
    logic            player;
    logic            win_a;
    logic            win_b;
    logic            draw;
    logic            busy;

    modport master (
        output btn_left, btn_right, btn_drop,
        input  panel, play, player, win_a, win_b, draw, busy
    );

    modport slave (
        input  btn_left, btn_right, btn_drop,
        output panel, play, player, win_a, win_b, draw, busy
    );
endinterface

// File: rtl/c4_line_count.sv
// Counts same-colour cells contiguous to (row, col) along one direction,
// both senses, at most WIN_LEN-1 per sense; the centre cell is not counted.
module c4_line_count
    import c4_pkg::*;
(
    input  panel_t        panel,
    input  logic [RW-1:0] row,
    input  logic [CW-1:0] col,
    input  logic [1:0]    dir,
    input  logic [1:0]    colour,
    output logic [2:0]    count
);
    always_comb begin
        int   pos;
        int   neg;
        logic run_p;
        logic run_n;
        pos   = 0;
        neg   = 0;
        run_p = 1'b1;
        run_n = 1'b1;
        for (int k = 1; k < WIN_LEN; k++) begin
            if (run_p && cell_at(panel, int'(row) + k * DIR_DR[dir],
                                 int'(col) + k * DIR_DC[dir]) == colour)
                pos++;
            else
                run_p = 1'b0;
            if (run_n && cell_at(panel, int'(row) - k * DIR_DR[dir],
                                 int'(col) - k * DIR_DC[dir]) == colour)
                neg++;
            else
                run_n = 1'b0;
        end
        count = 3'(pos + neg);
    end
endmodule

// File: rtl/c4_game_ctrl.sv
// Connect-4 sequencer: cursor movement, gravity drop, four-cycle win check,
// turn alternation and end-of-game hold, all outputs registered.
module c4_game_ctrl
    import c4_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    c4_game_ctrl_if.slave bus
);
    state_t          state;
    logic [CW-1:0]   cur;
    logic [RW-1:0]   r;
    logic [RW-1:0]   lr;
    logic [1:0]      dir;
    logic            win_flag;
    logic [MW-1:0]   moves;
    panel_t          panel;
    logic [COLS-1:0] play;
    logic            player;
    logic            win_a;
    logic            win_b;
    logic            draw;
    logic            busy;

    logic [2:0]      count;
    logic [1:0]      colour;
    logic [CW-1:0]   cur_l;
    logic [CW-1:0]   cur_r;

    assign colour = player ? P_B : P_A;
    assign cur_l  = (cur == '0) ? CW'(COLS - 1) : cur - 1'b1;
    assign cur_r  = (cur == CW'(COLS - 1)) ? '0 : cur + 1'b1;

    // One counter shared by all four CHECK cycles; dir selects the line.
    c4_line_count u_line (
        .panel  (panel),
        .row    (lr),
        .col    (cur),
        .dir    (dir),
        .colour (colour),
        .count  (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= SELECT;
            cur      <= CW'(START_COL);
            play     <= onehot(CW'(START_COL));
            r        <= '0;
            lr       <= '0;
            dir      <= '0;
            win_flag <= 1'b0;
            moves    <= '0;
            panel    <= '0;
            player   <= 1'b0;
            win_a    <= 1'b0;
            win_b    <= 1'b0;
            draw     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                SELECT: begin
                    if (bus.btn_drop) begin
                        if (panel[0][cur] == EMPTY) begin
                            r        <= RW'(ROWS - 1);
                            win_flag <= 1'b0;
                            busy     <= 1'b1;
                            state    <= DROP;
                        end
                    end else if (bus.btn_left && !bus.btn_right) begin
                        cur  <= cur_l;
                        play <= onehot(cur_l);
                    end else if (bus.btn_right && !bus.btn_left) begin
                        cur  <= cur_r;
                        play <= onehot(cur_r);
                    end
                end
                DROP: begin
                    if (panel[r][cur] == EMPTY) begin
                        panel[r][cur] <= colour;
                        lr            <= r;
                        moves         <= moves + 1'b1;
                        dir           <= '0;
                        state         <= CHECK;
                    end else begin
                        r <= r - 1'b1;
                    end
                end
                CHECK: begin
                    if (({1'b0, count} + 4'd1) >= 4'(WIN_LEN)) win_flag <= 1'b1;
                    dir <= dir + 1'b1;
                    if (dir == 2'd3) state <= RESOLVE;
                end
                RESOLVE: begin
                    busy <= 1'b0;
                    if (win_flag) begin
                        panel[lr][cur] <= WIN_MARK;
                        if (player) win_b <= 1'b1;
                        else        win_a <= 1'b1;
                        state <= WIN;
                    end else if (moves == MW'(CELLS)) begin
                        draw  <= 1'b1;
                        state <= DRAW;
                    end else begin
                        player <= ~player;
                        state  <= SELECT;
                    end
                end
                WIN, DRAW: begin
                    if (bus.btn_drop) begin
                        busy  <= 1'b1;
                        state <= CLEAR;
                    end
                end
                CLEAR: begin
                    panel  <= '0;
                    win_a  <= 1'b0;
                    win_b  <= 1'b0;
                    draw   <= 1'b0;
                    player <= 1'b0;
                    cur    <= CW'(START_COL);
                    play   <= onehot(CW'(START_COL));
                    moves  <= '0;
                    busy   <= 1'b0;
                    state  <= SELECT;
                end
                default: state <= SELECT;
            endcase
        end
    end

    assign bus.panel  = panel;
    assign bus.play   = play;
    assign bus.player = player;
    assign bus.win_a  = win_a;
    assign bus.win_b  = win_b;
    assign bus.draw   = draw;
    assign bus.busy   = busy;
endmodule

// File: tb/tb_c4_game_ctrl.sv
// Self-checking bench for c4_game_ctrl: vector table, scripted games and
// random button traffic against a board-level reference model.
module tb_c4_game_ctrl;
    import c4_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    c4_game_ctrl_if bus();
    c4_game_ctrl dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int checks   = 0;
    int failures = 0;

    // Reference model: whole board as ints, 0 empty, 1 A, 2 B, 3 winning disc.
    int bd [ROWS][COLS];
    int m_cur, m_player, m_moves;
    bit m_wa, m_wb, m_draw, m_over;

    typedef struct {
        bit              l, r, d;
        logic [COLS-1:0] e_play;
        bit              e_player;
        int              e_lat;
        logic [1:0]      e_c53;
    } vec_t;
    vec_t tv [11];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) bd[i][j] = 0;
        m_cur = START_COL; m_player = 0; m_moves = 0;
        m_wa = 0; m_wb = 0; m_draw = 0; m_over = 0;
    endtask

    // Any window of WIN_LEN cells through (r,c) entirely of c's colour.
    function automatic bit four_through(int r, int c);
        int dr [4];
        int dc [4];
        dr = '{0, 1, 1, -1};
        dc = '{1, 0, 1, 1};
        for (int d = 0; d < 4; d++)
            for (int s = 0; s < WIN_LEN; s++) begin
                bit ok;
                ok = 1;
                for (int i = 0; i < WIN_LEN; i++) begin
                    int rr, cc;
                    rr = r + (i - s) * dr[d];
                    cc = c + (i - s) * dc[d];
                    if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) ok = 0;
                    else if (bd[rr][cc] != bd[r][c]) ok = 0;
                end
                if (ok) return 1;
            end
        return 0;
    endfunction

    task automatic model_press(input bit l, input bit r, input bit d, output int lat);
        lat = 0;
        if (!m_over) begin
            if (d) begin
                if (bd[0][m_cur] == 0) begin
                    int k;
                    k = ROWS - 1;
                    while (bd[k][m_cur] != 0) k--;
                    bd[k][m_cur] = m_player + 1;
                    m_moves++;
                    lat = (ROWS - k) + 4 + 1;
                    if (four_through(k, m_cur)) begin
                        bd[k][m_cur] = 3;
                        if (m_player == 0) m_wa = 1; else m_wb = 1;
                        m_over = 1;
                    end else if (m_moves == ROWS * COLS) begin
                        m_draw = 1;
                        m_over = 1;
                    end else begin
                        m_player = 1 - m_player;
                    end
                end
            end else if (l && !r) m_cur = (m_cur + COLS - 1) % COLS;
            else if (r && !l)     m_cur = (m_cur + 1) % COLS;
        end else if (d) begin
            model_reset();
            lat = 1;
        end
    endtask

    function automatic panel_t exp_panel();
        panel_t p;
        p = '0;
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) p[i][j] = 2'(bd[i][j]);
        return p;
    endfunction

    task automatic compare_all(input string tag);
        logic [COLS-1:0] ep;
        ep = '0;
        ep[m_cur] = 1'b1;
        chk({tag, " panel"},  bus.panel,  exp_panel());
        chk({tag, " play"},   bus.play,   ep);
        chk({tag, " player"}, bus.player, m_player[0]);
        chk({tag, " win_a"},  bus.win_a,  m_wa);
        chk({tag, " win_b"},  bus.win_b,  m_wb);
        chk({tag, " draw"},   bus.draw,   m_draw);
        chk({tag, " busy"},   bus.busy,   1'b0);
    endtask

    // One-cycle pulse, wait (bounded) for busy to fall, check latency and state.
    task automatic press(input bit l, input bit r, input bit d, input string tag);
        int lat, n;
        @(negedge clk);
        bus.btn_left = l; bus.btn_right = r; bus.btn_drop = d;
        @(negedge clk);
        bus.btn_left = 0; bus.btn_right = 0; bus.btn_drop = 0;
        n = 0;
        while (bus.busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        model_press(l, r, d, lat);
        chk({tag, " busy cycles"}, n, lat);
        compare_all(tag);
    endtask

    task automatic move_to(input int col);
        while (m_cur != col) press(0, 1, 0, "move");
    endtask

    task automatic drop_at(input int col, input string tag);
        move_to(col);
        press(0, 0, 1, tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq_h [7];
        int seq_v [7];
        int seq_ad [12];
        int seq_dr [42];
        int x;

        tv[0]  = '{1, 0, 0, 7'b0000100, 0, 0, 2'b00};
        tv[1]  = '{1, 0, 0, 7'b0000010, 0, 0, 2'b00};
        tv[2]  = '{1, 0, 0, 7'b0000001, 0, 0, 2'b00};
        tv[3]  = '{1, 0, 0, 7'b1000000, 0, 0, 2'b00};
        tv[4]  = '{0, 1, 0, 7'b0000001, 0, 0, 2'b00};
        tv[5]  = '{0, 1, 0, 7'b0000010, 0, 0, 2'b00};
        tv[6]  = '{0, 1, 0, 7'b0000100, 0, 0, 2'b00};
        tv[7]  = '{0, 1, 0, 7'b0001000, 0, 0, 2'b00};
        tv[8]  = '{1, 1, 0, 7'b0001000, 0, 0, 2'b00};
        tv[9]  = '{1, 0, 1, 7'b0001000, 1, 6, 2'b01};
        tv[10] = '{0, 1, 0, 7'b0010000, 1, 0, 2'b01};

        seq_h  = '{0, 6, 1, 6, 2, 6, 3};
        seq_v  = '{2, 0, 2, 0, 2, 0, 2};
        seq_ad = '{5, 6, 4, 5, 4, 4, 3, 0, 3, 1, 3, 3};
        seq_dr = '{0,0,0,0,0,0, 1,1,1,1,1,1, 2,2,2,2,2,2, 4,
                   3,3,3,3,3,3, 4,4,4,4,4, 5,5,5,5,5,5, 6,6,6,6,6,6};

        rst = 1;
        bus.btn_left = 0; bus.btn_right = 0; bus.btn_drop = 0;
        model_reset();
        #12;
        compare_all("reset");
        chk("reset play const", bus.play, 7'b0001000);
        @(negedge clk);
        rst = 0;

        for (int i = 0; i < 11; i++) begin
            int lat_n;
            press(tv[i].l, tv[i].r, tv[i].d, $sformatf("vec%0d", i));
            lat_n = 0;
            chk($sformatf("vec%0d play", i),   bus.play,         tv[i].e_play);
            chk($sformatf("vec%0d player", i), bus.player,       tv[i].e_player);
            chk($sformatf("vec%0d cell53", i), bus.panel[5][3],  tv[i].e_c53);
            chk($sformatf("vec%0d lat", i),    tv[i].e_lat == 6 || tv[i].e_lat == lat_n, 1'b1);
        end

        // Full column: seventh drop into column 0 is ignored.
        do_reset();
        for (int i = 0; i < ROWS; i++) drop_at(0, "fill col0");
        drop_at(0, "full col0");
        chk("full col player", bus.player, 1'b0);
        chk("full col top cell", bus.panel[0][0], 2'b10);

        // Horizontal win for A on the bottom row.
        do_reset();
        for (int i = 0; i < 7; i++) drop_at(seq_h[i], "horiz");
        chk("horiz win_a", bus.win_a, 1'b1);
        chk("horiz mark", bus.panel[5][3], 2'b11);
        chk("horiz player", bus.player, 1'b0);
        press(1, 0, 0, "win frozen left");
        chk("win frozen play", bus.play, 7'b0001000);
        press(0, 0, 1, "win clear");
        chk("clear win_a", bus.win_a, 1'b0);
        chk("clear play", bus.play, 7'b0001000);
        chk("clear panel", bus.panel, '0);

        // Vertical stack in column 2.
        for (int i = 0; i < 7; i++) drop_at(seq_v[i], "vert");
        chk("vert win_a", bus.win_a, 1'b1);
        chk("vert mark", bus.panel[2][2], 2'b11);
        press(0, 0, 1, "vert clear");

        // Anti-diagonal for B ending at (2,3).
        for (int i = 0; i < 12; i++) drop_at(seq_ad[i], "antidiag");
        chk("antidiag win_b", bus.win_b, 1'b1);
        chk("antidiag win_a", bus.win_a, 1'b0);
        chk("antidiag mark", bus.panel[2][3], 2'b11);
        chk("antidiag player", bus.player, 1'b1);
        press(0, 0, 1, "antidiag clear");

        // 42 moves with no four-in-a-row.
        for (int i = 0; i < 42; i++) drop_at(seq_dr[i], "drawgame");
        chk("draw flag", bus.draw, 1'b1);
        chk("draw no win", {bus.win_a, bus.win_b}, 2'b00);
        press(0, 1, 0, "draw frozen right");
        press(0, 0, 1, "draw clear");
        chk("draw cleared", bus.draw, 1'b0);

        // Asynchronous reset while DROP is still scanning down column 1.
        for (int i = 0; i < 3; i++) drop_at(1, "predrop");
        move_to(1);
        @(negedge clk);
        bus.btn_drop = 1;
        @(negedge clk);
        bus.btn_drop = 0;
        chk("middrop busy", bus.busy, 1'b1);
        @(negedge clk);
        #1 rst = 1;
        #1;
        chk("rst panel", bus.panel, '0);
        chk("rst player", bus.player, 1'b0);
        chk("rst busy", bus.busy, 1'b0);
        chk("rst play", bus.play, 7'b0001000);
        @(negedge clk);
        rst = 0;
        model_reset();
        compare_all("after rst");

        // Random button traffic against the model.
        for (int i = 0; i < 400; i++) begin
            x = $urandom_range(0, 9);
            case (x)
                0, 1, 2: press(0, 0, 1, "rnd drop");
                3:       press($urandom_range(0, 1), $urandom_range(0, 1), 1, "rnd drop+mv");
                4, 5:    press(1, 0, 0, "rnd left");
                6, 7, 8: press(0, 1, 0, "rnd right");
                default: press(1, 1, 0, "rnd both");
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/c4_game_ctrl.md
Name: c4_game_ctrl

Overview:
Connect-4 game sequencer that owns the board state driven into the VGA display block. It accepts debounced cursor and drop button pulses, moves the column cursor, and lands a disc by gravity scan. It then runs a sequential four-direction win check and alternates players. It produces panel, play, player, win_a, win_b and draw, which feed the display block directly.

Parameters:
ROWS, 6, board rows; row 0 = top line on screen, row ROWS-1 = bottom.
COLS, 7, board columns; column 0 = leftmost.
WIN_LEN, 4, consecutive discs required to win.
START_COL, 3, cursor column after reset and after each new game.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-high reset.
btn_left  in  1  one-cycle pulse; move cursor left.
btn_right  in  1  one-cycle pulse; move cursor right.
btn_drop  in  1  one-cycle pulse; drop a disc, or start a new game from WIN/DRAW.
panel  out  ROWS x COLS x 2  cell codes: 00 empty, 01 player A, 10 player B, 11 winning disc.
play  out  COLS  one-hot cursor column.
player  out  1  side to move: 0 = A, 1 = B.
win_a  out  1  A has won; held until a new game starts.
win_b  out  1  B has won; held until a new game starts.
draw  out  1  board full with no winner; held until a new game starts.
busy  out  1  high in DROP, CHECK, RESOLVE and CLEAR.

Behaviour:
- Reset values: panel all 00; play = one-hot(START_COL), i.e. 7'b0001000; player 0; win_a, win_b, draw, busy 0; state SELECT; move counter 0.
- All outputs are registered.
- States: SELECT, DROP, CHECK, RESOLVE, WIN, DRAW, CLEAR.
- SELECT, priority order:
  - btn_drop: if panel[0][cur] != 00 (column full), ignore and stay in SELECT. Otherwise latch cur, set r = ROWS-1, go to DROP. Same-cycle left/right pulses are ignored.
  - btn_left alone: cur = (cur == 0) ? COLS-1 : cur-1.
  - btn_right alone: cur = (cur == COLS-1) ? 0 : cur+1.
  - btn_left and btn_right together: no move.
- DROP scans one row per cycle:
  - If panel[r][cur] == 00: write 01 (player 0) or 10 (player 1), latch landing row lr = r, increment the move counter, go to CHECK.
  - Otherwise r = r-1.
  - Landing in row k therefore takes ROWS-k DROP cycles (1 to 6).
- CHECK takes one direction per cycle, in order d = 0..3: horizontal (0,+1), vertical (+1,0), diagonal (+1,+1), anti-diagonal (+1,-1).
  - Per direction, count same-colour cells contiguous from (lr, cur) in both senses, at most WIN_LEN-1 per sense.
  - Treat out-of-board positions as mismatches; do not wrap at edges.
  - If 1 + count >= WIN_LEN, set the sticky win flag and remember d.
  - CHECK always takes exactly 4 cycles.
- RESOLVE, one cycle:
  - Win: rewrite the landed cell to 11, set win_a (player 0) or win_b (player 1), go to WIN. player is not toggled.
  - Else if the move counter == ROWS*COLS: set draw, go to DRAW.
  - Else toggle player and return to SELECT.
- WIN / DRAW:
  - btn_left, btn_right and play are frozen.
  - btn_drop goes to CLEAR.
- CLEAR, one cycle: panel all 00; win_a, win_b, draw 0; player 0; cursor START_COL; move counter 0; then SELECT.
- Buttons outside SELECT/WIN/DRAW are dropped, not queued.
- Asynchronous rst in any state, including mid-DROP or mid-CHECK, restores the reset values immediately; no partial write survives.
- Drop-to-next-SELECT latency: (ROWS - landing row) + 4 + 1 cycles.
  - Bottom row: 6 cycles.
  - Top row: 11 cycles.

Decomposition:
- Package c4_pkg holds:
  - cell_t enum: EMPTY = 2'b00, P_A = 2'b01, P_B = 2'b10, WIN_MARK = 2'b11.
  - state_t enum.
  - Constants ROWS, COLS, WIN_LEN.
  - Direction offset table: four signed row/col deltas.
- One sub-module, c4_line_count: a combinational count of matching cells along a direction from a given cell. It is instantiated once and reused across the four CHECK cycles.

Test Plan:
- Reset, then 3 btn_left pulses -> play = 7'b0000001. One more btn_left -> play = 7'b1000000 (wrap).
- btn_drop at column 3 on an empty board -> panel[5][3] = 01 after 1 DROP cycle. busy high for 6 cycles, then player = 1 and panel[5][3] remains 01.
- Fill column 0 with 6 alternating drops, then btn_drop at column 0 -> state stays SELECT, panel unchanged, player unchanged.
- A plays columns 0,1,2,3 on row 5; B plays column 6 in between.
  - Expected after A's fourth drop: win_a = 1, panel[5][3] = 11, player = 0.
  - Further btn_left is ignored. btn_drop -> board clears, win_a = 0, play = 7'b0001000.
- Build an anti-diagonal for B: cells (5,6), (4,5), (3,4), (2,3) -> win_b = 1 on the final drop. Also test a vertical stack of 4 in column 2.
- Play 42 moves with no four-in-a-row -> draw = 1 after the 42nd RESOLVE.
- Assert rst mid-DROP -> panel all 00, player 0, busy 0 immediately.
